uart_imem_loader: RTL and testbench

Hardware instruction-memory loader for the Apple RISC-V SoC. It receives an 8N1 UART byte stream on the SoC's UART RX pin while `load_imem` is high, packs the bytes little-endian into 32-bit words, and writes them sequentially into instruction RAM from address 0. It is the in-system write path for the instruction-RAM load that simulation performs through backdoor writes. It sits between the pad-level `uart0_rxd` and the imem write port, and the imem write port is muxed ahead of the CPU.

---
 rtl/apple_loader_pkg.sv | 30 +++
 rtl/uart_rx_core.sv | 99 +++++++++
 rtl/uart_imem_loader.sv | 154 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package apple_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned DEF_BAUD_DIV = 868;
  localparam int unsigned HALF_BIT     = DEF_BAUD_DIV / 2;

  function automatic int unsigned half_bit(input int unsigned div);
    return div / 2;
  endfunction

  // Byte enables for a partial word holding idx bytes; idx 0 means a full word.
  function automatic logic [3:0] flush_be(input logic [1:0] idx);
    logic [3:0] be;
    case (idx)
      2'd1:    be = 4'h1;
      2'd2:    be = 4'h3;
      2'd3:    be = 4'h7;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch reject on start bit.
module uart_rx_core
  import apple_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int unsigned HALF  = half_bit(BAUD_DIV);
  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             tick_half, tick_bit;

  assign tick_half = (cnt_q == CNT_W'(HALF - 1));
  assign tick_bit  = (cnt_q == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !sync2_q) state_d = RX_START;
      RX_START: if (tick_half) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_bit && (bit_q == 3'd7)) state_d = RX_STOP;
      RX_STOP:  if (tick_bit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      RX_START: if (tick_half) cnt_d = '0;
      RX_DATA: begin
        if (tick_bit) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (tick_bit) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_data  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Packs UART bytes little-endian into words and writes them to imem from address 0.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
module uart_imem_loader
  import apple_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV        = DEF_BAUD_DIV,
  parameter int unsigned IMEM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_imem,
  input  logic                       uart_rxd,
  output logic                       imem_wr,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [3:0]                 imem_byte_en,
  output logic                       busy,
  output logic [IMEM_ADDR_WIDTH-2:0] word_count,
  output logic                       frame_err,
  output logic                       overflow,
  output logic [31:0]                checksum
);

  localparam int unsigned AW = IMEM_ADDR_WIDTH;
  localparam logic [AW-1:0] TOP_ADDR = {{(AW-2){1'b1}}, 2'b00};

  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;

  logic          load_q;
  logic [1:0]    idx_q, idx_d, idx_base;
  logic [31:0]   word_q, word_d, word_base;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-2:0] wc_q, wc_d;
  logic          ferr_q, ferr_d, ovf_q, ovf_d, busy_q, busy_d;
  logic          rise, fall, accept;

  uart_rx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .uart_rxd(uart_rxd),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ferr (rx_ferr)
  );

  assign rise   = load_imem && !load_q;
  assign fall   = !load_imem && load_q;
  // A byte landing on the falling-edge cycle still belongs to the load.
  assign accept = rx_valid && (load_imem || load_q);

  always_comb begin
    idx_base  = rise ? 2'd0 : idx_q;
    word_base = (idx_base == 2'd0) ? '0 : word_q;
    word_d    = word_base;
    idx_d     = idx_base;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;
    be_d      = be_q;
    if (accept) begin
      word_d[{idx_base, 3'b000} +: 8] = rx_data;
      idx_d = idx_base + 2'd1;
    end
    if (accept && (idx_base == 2'd3)) begin
      wr_d    = 1'b1;
      wdata_d = word_d;
      be_d    = 4'hF;
    end else if (fall && (idx_d != 2'd0)) begin
      wr_d    = 1'b1;
      wdata_d = word_d;
      be_d    = flush_be(idx_d);
      idx_d   = 2'd0;
    end
  end

  always_comb begin
    addr_d = addr_q;
    wc_d   = wc_q;
    ovf_d  = ovf_q;
    ferr_d = ferr_q || rx_ferr;
    busy_d = load_imem || (load_q && wr_d);
    if (rise) begin
      addr_d = '0;
      wc_d   = '0;
      ovf_d  = 1'b0;
      ferr_d = rx_ferr;
    end else if (wr_q) begin
      addr_d = addr_q + AW'(4);
      wc_d   = wc_q + 1'b1;
      if (addr_q == TOP_ADDR) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= 1'b0;
      idx_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      load_q  <= load_imem;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] ck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_q <= '0;
    end else if (rise) begin
      ck_q <= '0;
    end else if (wr_q) begin
      ck_q <= ck_q + wdata_q;
    end
  end

  assign checksum = ck_q;
`else
  assign checksum = '0;
`endif

  assign imem_wr      = wr_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign imem_byte_en = be_q;
  assign busy         = busy_q;
  assign word_count   = wc_q;
  assign frame_err    = ferr_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: a 16-bit and a 4-bit address instance share the RX line.
`timescale 1ns/1ps
module tb_uart_imem_loader;
  import apple_loader_pkg::*;

  localparam int unsigned BD = 16;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        load_w = 1'b0;
  logic        rxd = 1'b1;

  logic        wr, busy, ferr, ovf;
  logic [15:0] addr;
  logic [31:0] wdata, ck;
  logic [3:0]  be;
  logic [14:0] wc;

  logic        wr_w, busy_w, ferr_w, ovf_w;
  logic [3:0]  addr_w;
  logic [31:0] wdata_w, ck_w;
  logic [3:0]  be_w;
  logic [2:0]  wc_w;

  wr_t q[$];
  wr_t qw[$];
  wr_t em, ew;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned rxv_count = 0;

  uart_imem_loader #(.BAUD_DIV(BD), .IMEM_ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load_imem(load), .uart_rxd(rxd),
    .imem_wr(wr), .imem_addr(addr), .imem_wdata(wdata), .imem_byte_en(be),
    .busy(busy), .word_count(wc), .frame_err(ferr), .overflow(ovf), .checksum(ck)
  );

  uart_imem_loader #(.BAUD_DIV(BD), .IMEM_ADDR_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .load_imem(load_w), .uart_rxd(rxd),
    .imem_wr(wr_w), .imem_addr(addr_w), .imem_wdata(wdata_w), .imem_byte_en(be_w),
    .busy(busy_w), .word_count(wc_w), .frame_err(ferr_w), .overflow(ovf_w), .checksum(ck_w)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe pops and compares the oldest expected write.
  always @(negedge clk) begin
    if (dut.rx_valid === 1'b1) rxv_count++;
    if (wr === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL main_unexpected_write addr=%h data=%h be=%h required=no write", addr, wdata, be);
      end else begin
        em = q.pop_front();
        if (addr !== em.addr || wdata !== em.data || be !== em.be)
          $display("FAIL main_write got addr=%h data=%h be=%h required addr=%h data=%h be=%h",
                   addr, wdata, be, em.addr, em.data, em.be);
        else n_pass++;
      end
    end
    if (wr_w === 1'b1) begin
      n_checks++;
      if (qw.size() == 0) begin
        $display("FAIL wrap_unexpected_write addr=%h data=%h be=%h required=no write", addr_w, wdata_w, be_w);
      end else begin
        ew = qw.pop_front();
        if ({12'h0, addr_w} !== ew.addr || wdata_w !== ew.data || be_w !== ew.be)
          $display("FAIL wrap_write got addr=%h data=%h be=%h required addr=%h data=%h be=%h",
                   addr_w, wdata_w, be_w, ew.addr, ew.data, ew.be);
        else n_pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BD) @(negedge clk);
    end
    rxd = stop;
    repeat (BD) @(negedge clk);
    rxd = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic set_load(input logic v);
    @(negedge clk) load = v;
  endtask

  task automatic wait_drain(output int unsigned left);
    int unsigned k = 0;
    while ((q.size() != 0 || qw.size() != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    left = q.size() + qw.size();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr, busy, ferr, ovf} !== 4'b0000)
      $display("FAIL reset_flags got=%b required=0000", {wr, busy, ferr, ovf});
    else n_pass++;
    n_checks++;
    if (addr !== 16'h0 || wc !== 15'h0)
      $display("FAIL reset_addr_count got addr=%h wc=%h required 0", addr, wc);
    else n_pass++;
    n_checks++;
    if (wdata !== 32'h0 || be !== 4'h0)
      $display("FAIL reset_data got data=%h be=%h required 0", wdata, be);
    else n_pass++;
    n_checks++;
    if (ck !== 32'h0)
      $display("FAIL reset_checksum got=%h required=0", ck);
    else n_pass++;
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_word();
    int unsigned left;
    set_load(1'b1);
    q.push_back('{addr: 16'h0000, data: 32'h0000_0013, be: 4'hF});
    send_word(32'h0000_0013);
    wait_drain(left);
    n_checks++;
    if (left !== 0) $display("FAIL single_drain got pending=%0d required=0", left);
    else n_pass++;
    n_checks++;
    if (wc !== 15'd1 || addr !== 16'h0004 || busy !== 1'b1)
      $display("FAIL single_state got wc=%0d addr=%h busy=%b required wc=1 addr=0004 busy=1", wc, addr, busy);
    else n_pass++;
    set_load(1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_end got=%b required=0", busy);
    else n_pass++;
  endtask

  task automatic test_partial_flush();
    int unsigned left;
    set_load(1'b1);
    q.push_back('{addr: 16'h0000, data: 32'h0403_0201, be: 4'hF});
    q.push_back('{addr: 16'h0004, data: 32'h0000_0605, be: 4'h3});
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr !== 1'b1 || busy !== 1'b1)
      $display("FAIL flush_cycle got wr=%b busy=%b required wr=1 busy=1", wr, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wr !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_busy_fall got wr=%b busy=%b required wr=0 busy=0", wr, busy);
    else n_pass++;
    wait_drain(left);
    n_checks++;
    if (left !== 0 || wc !== 15'd2)
      $display("FAIL flush_drain got pending=%0d wc=%0d required pending=0 wc=2", left, wc);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    int unsigned left;
    set_load(1'b1);
    q.push_back('{addr: 16'h0000, data: 32'h4433_2211, be: 4'hF});
    send_byte(8'hAA, 1'b0);
    n_checks++;
    if (ferr !== 1'b1) $display("FAIL ferr_set got=%b required=1", ferr);
    else n_pass++;
    send_word(32'h4433_2211);
    wait_drain(left);
    n_checks++;
    if (left !== 0 || wc !== 15'd1 || ferr !== 1'b1)
      $display("FAIL ferr_after got pending=%0d wc=%0d ferr=%b required 0/1/1", left, wc, ferr);
    else n_pass++;
    set_load(1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch();
    int unsigned v0, left;
    set_load(1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ferr !== 1'b0) $display("FAIL ferr_cleared got=%b required=0", ferr);
    else n_pass++;
    v0 = rxv_count;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (BD * 12) @(negedge clk);
    n_checks++;
    if (rxv_count !== v0 || wc !== 15'd0)
      $display("FAIL glitch_no_byte got rx_valid=%0d wc=%0d required rx_valid=%0d wc=0", rxv_count, wc, v0);
    else n_pass++;
    n_checks++;
    if (dut.u_rx.state_q !== RX_IDLE)
      $display("FAIL glitch_idle got=%0d required=%0d", dut.u_rx.state_q, RX_IDLE);
    else n_pass++;
    q.push_back('{addr: 16'h0000, data: 32'hA4A3_A2A1, be: 4'hF});
    send_word(32'hA4A3_A2A1);
    wait_drain(left);
    n_checks++;
    if (left !== 0) $display("FAIL glitch_recover got pending=%0d required=0", left);
    else n_pass++;
    set_load(1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midword();
    int unsigned left;
    set_load(1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    q.push_back('{addr: 16'h0000, data: 32'h0D0C_0B0A, be: 4'hF});
    send_word(32'h0D0C_0B0A);
    wait_drain(left);
    n_checks++;
    if (left !== 0 || wc !== 15'd1)
      $display("FAIL reset_midword got pending=%0d wc=%0d required 0/1", left, wc);
    else n_pass++;
    set_load(1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    int unsigned left;
    logic [31:0] w;
    @(negedge clk) load_w = 1'b1;
    for (int n = 0; n < 5; n++) begin
      w = 32'hC0DE_0000 + 32'(n);
      qw.push_back('{addr: 16'((n * 4) % 16), data: w, be: 4'hF});
      send_word(w);
      if (n == 3) begin
        n_checks++;
        if (ovf_w !== 1'b1 || addr_w !== 4'h0)
          $display("FAIL wrap_at_top got ovf=%b addr=%h required ovf=1 addr=0", ovf_w, addr_w);
        else n_pass++;
      end else if (n == 2) begin
        n_checks++;
        if (ovf_w !== 1'b0) $display("FAIL wrap_early got=%b required=0", ovf_w);
        else n_pass++;
      end
    end
    wait_drain(left);
    n_checks++;
    if (left !== 0 || ovf_w !== 1'b1 || wc_w !== 3'd5 || addr_w !== 4'h4)
      $display("FAIL wrap_final got pending=%0d ovf=%b wc=%0d addr=%h required 0/1/5/4",
               left, ovf_w, wc_w, addr_w);
    else n_pass++;
    @(negedge clk) load_w = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_checksum();
    int unsigned left;
    logic [31:0] exp_ck;
`ifdef LOADER_CHECKSUM_EN
    exp_ck = 32'h0000_0001;
`else
    exp_ck = 32'h0000_0000;
`endif
    set_load(1'b1);
    q.push_back('{addr: 16'h0000, data: 32'hFFFF_FFFF, be: 4'hF});
    q.push_back('{addr: 16'h0004, data: 32'h0000_0002, be: 4'hF});
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0002);
    wait_drain(left);
    @(negedge clk);
    n_checks++;
    if (left !== 0 || ck !== exp_ck)
      $display("FAIL checksum_sum got pending=%0d ck=%h required 0/%h", left, ck, exp_ck);
    else n_pass++;
    set_load(1'b0);
    repeat (2) @(negedge clk);
    set_load(1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ck !== 32'h0 || addr !== 16'h0 || wc !== 15'd0)
      $display("FAIL checksum_restart got ck=%h addr=%h wc=%0d required 0/0/0", ck, addr, wc);
    else n_pass++;
    set_load(1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_partial_flush();
    test_frame_err();
    test_glitch();
    test_reset_midword();
    test_wrap();
    test_checksum();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
